pulse_param_loader: RTL
=======================

// Module: pulse_param_loader
// PURPOSE
//  Assembles the pulse-sequence parameter set from the host byte stream (UART RX bytes).
//  Checks each frame, then holds the new set as a pending set.
//  Commits the pending set to the pulse generator's parameter inputs only at a period boundary,
//  so a running sequence never sees a mix of old and new values.
//  Sits between the UART receiver and the pulse generator (per/p1wid/del/p2wid/nut_w/nut_d/cp/p_bl/p_bl_off/bl).
// PARAMETERS
//  HDR_BYTE     8'hAA   frame header byte
//  TIMEOUT_CYC  500000  max clk cycles between bytes inside a frame before abort (10 ms @ 50 MHz)
//  TO_W         20      timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk          in   1   system clock; only clock in this block
//  reset        in   1   asynchronous, active-low reset
//  rx_data      in   8   received byte
//  rx_valid     in   1   one-cycle strobe: rx_data valid
//  commit_strobe in  1   one-cycle strobe from the pulse generator at counter wrap (period boundary)
//  commit_now   in   1   level: commit immediately, without waiting for a period boundary
//  per          out  32  period, cycles
//  p1wid        out  16  pulse 1 width
//  del          out  16  inter-pulse delay
//  p2wid        out  16  pulse 2 / CPMG pulse width
//  nut_w        out  8   nutation pulse width
//  nut_d        out  16  nutation pulse delay
//  cp           out  8   0=CW, 1=Hahn, N>1=CPMG N
//  p_bl         out  8   block-open start after pulse
//  p_bl_off     out  16  block-open end after pulse
//  bl           out  1   blocking enable
//  pending      out  1   a validated set is waiting for commit
//  frame_ok     out  1   one-cycle pulse: frame accepted
//  frame_err    out  1   one-cycle pulse: checksum error, timeout or invalid content
// BEHAVIOUR
//  Reset values, live and pending sets:
//   - per=4000, p1wid=30, del=200, p2wid=60, nut_w=0, nut_d=0, cp=3, p_bl=50, p_bl_off=100, bl=1.
//   - pending=0, frame_ok=0, frame_err=0, FSM=HUNT.
//  Frame format: HDR_BYTE, 18 payload bytes, 1 checksum byte.
//   - Payload fields are big-endian, in port order: per(4) p1wid(2) del(2) p2wid(2) nut_w(1) nut_d(2)
//     cp(1) p_bl(1) p_bl_off(2) bl(1). Only bit0 of the bl byte is used.
//   - Checksum = 8-bit modular sum of the 18 payload bytes.
//  FSM states:
//   - HUNT: rx_valid & rx_data==HDR_BYTE -> PAYLOAD, idx=0, sum=0. Any other byte is ignored.
//   - PAYLOAD: each rx_valid shifts the byte into the assembly buffer at idx and adds it to sum;
//     at idx==17 -> CSUM.
//   - CSUM: on rx_valid -> CHECK, with the received checksum latched.
//   - CHECK (1 cycle, no byte consumed) -> always HUNT. Frame is OK iff:
//     checksum matches, per!=0, and per > p1wid+del+p2wid (checked at 33-bit width, no truncation).
//     - OK: pending set <= assembly buffer, pending=1, frame_ok=1.
//     - not OK: frame_err=1; pending set and pending flag unchanged.
//  A header byte received inside PAYLOAD or CSUM is data, not a resync.
//  Timeout: counter clears on every rx_valid. In PAYLOAD or CSUM, reaching TIMEOUT_CYC gives
//   frame_err=1 and FSM -> HUNT; partial data is discarded.
//  Commit:
//   - When pending=1 and (commit_strobe | commit_now): live <= pending set and pending <= 0
//     on the next edge.
//   - Outputs are registered; they change exactly 1 cycle after the qualifying strobe.
//   - If CHECK accepts a frame in the same cycle as commit_strobe: the older pending set commits,
//     the new set becomes pending, and pending stays 1.
//   - A new OK frame while pending=1 overwrites the pending set; the last frame wins.
//   - commit_strobe with pending=0: no effect.
//  reset asserted mid-frame or mid-commit: everything returns to reset values at once.
//   Nothing partial is ever written to the live set.
//  frame_ok and frame_err are never high in the same cycle.
// STRUCTURE
//  Shared package pulse_pkg:
//   - Field widths and byte offsets, PAYLOAD_LEN=18, reset defaults.
//   - Parameter-set struct/typedef (same order as the ports).
//  Sub-module param_frame_rx: HUNT/PAYLOAD/CSUM/CHECK FSM, timeout counter, assembly buffer.
//   Outputs a 144-bit set plus ok/err strobes.
//  Top level holds the pending and live registers and the commit logic.
// TESTING
//  1. Reset, no input -> outputs equal the defaults; pending=0.
//  2. Valid frame (per=10000, p1wid=40, del=300, p2wid=80, cp=1, ...) with correct sum
//     -> frame_ok 1 cycle after the checksum byte; pending=1; per stays 4000 until commit_strobe;
//     1 cycle later per=10000 and pending=0.
//  3. Same frame with the checksum off by 1 -> frame_err pulse; pending=0; outputs unchanged.
//  4. Frame stopped after 7 payload bytes, idle TIMEOUT_CYC cycles -> frame_err; a following full
//     valid frame is accepted.
//  5. Frame A accepted, then frame B accepted before any strobe, then commit_strobe -> live=B.
//     Frame C's CHECK cycle coincides with commit_strobe -> live=B, pending=C.
//  6. per=100, p1wid=40, del=40, p2wid=30 (sum 110 >= per) -> frame_err.
//     reset pulsed mid-payload -> defaults restored, FSM in HUNT.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and reset defaults for the pulse parameter loader.
// The set struct is in wire order, so shifting bytes in MSB-first yields the big-endian layout.
package pulse_pkg;

  localparam int PAYLOAD_LEN = 18;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic [7:0]  bl;
  } param_set_t;

  localparam int SET_W = $bits(param_set_t);

  localparam param_set_t PARAM_DEFAULT = '{
    per:      32'd4000,
    p1wid:    16'd30,
    del:      16'd200,
    p2wid:    16'd60,
    nut_w:    8'd0,
    nut_d:    16'd0,
    cp:       8'd3,
    p_bl:     8'd50,
    p_bl_off: 16'd100,
    bl:       8'd1
  };

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2,
    ST_CHECK   = 2'd3
  } rx_state_e;

  // Period must strictly exceed the pulse train; widened to 33 bits so nothing wraps.
  function automatic logic set_is_sane(param_set_t s);
    logic [32:0] train;
    train = 33'(s.p1wid) + 33'(s.del) + 33'(s.p2wid);
    return (s.per != 32'd0) && ({1'b0, s.per} > train);
  endfunction

endpackage

// File: rtl/param_frame_rx.sv
// Frame assembler: hunts for the header, collects 18 payload bytes and a checksum, then judges
// the frame for one cycle (ok_o / err_o). A stalled frame is dropped after TIMEOUT_CYC idle cycles.
module param_frame_rx
  import pulse_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CYC = 500000,
  parameter int         TO_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output param_set_t set_o,
  output logic       ok_o,
  output logic       err_o
);

  rx_state_e        state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       csum_q, csum_d;
  logic [SET_W-1:0] buf_q, buf_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic in_frame;
  logic timeout;
  logic good;

  assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign timeout  = in_frame && (to_cnt_q == TO_W'(TIMEOUT_CYC));
  assign good     = (sum_q == csum_q) && set_is_sane(param_set_t'(buf_q));
  assign set_o    = param_set_t'(buf_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    csum_d   = csum_q;
    buf_d    = buf_q;
    ok_o     = 1'b0;
    err_o    = 1'b0;
    to_cnt_d = (rx_valid_i || !in_frame || timeout) ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      ST_HUNT: begin
        if (rx_valid_i && rx_data_i == HDR_BYTE) begin
          state_d = ST_PAYLOAD;
          idx_d   = 5'd0;
          sum_d   = 8'd0;
        end
      end
      ST_PAYLOAD: begin
        if (timeout) begin
          err_o   = 1'b1;
          state_d = ST_HUNT;
        end else if (rx_valid_i) begin
          buf_d = {buf_q[SET_W-9:0], rx_data_i};
          sum_d = sum_q + rx_data_i;
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'(PAYLOAD_LEN - 1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (timeout) begin
          err_o   = 1'b1;
          state_d = ST_HUNT;
        end else if (rx_valid_i) begin
          csum_d  = rx_data_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        ok_o    = good;
        err_o   = !good;
        state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      sum_q    <= '0;
      csum_q   <= '0;
      buf_q    <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      csum_q   <= csum_d;
      buf_q    <= buf_d;
      to_cnt_q <= to_cnt_d;
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Loads pulse parameters from the host byte stream into a pending set, and swaps it into the
// live (registered) outputs only at a period boundary or on commit_now; outputs move 1 cycle later.
module pulse_param_loader
  import pulse_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CYC = 500000,
  parameter int         TO_W        = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        commit_strobe,
  input  logic        commit_now,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        pending,
  output logic        frame_ok,
  output logic        frame_err
);

  param_set_t rx_set;
  logic       rx_ok;
  logic       rx_err;

  param_set_t live_q, live_d;
  param_set_t pend_set_q, pend_set_d;
  logic       pending_q, pending_d;
  logic       commit;

  param_frame_rx #(
    .HDR_BYTE   (HDR_BYTE),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_frame_rx (
    .clk       (clk),
    .rst_n     (reset),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .set_o     (rx_set),
    .ok_o      (rx_ok),
    .err_o     (rx_err)
  );

  assign commit = pending_q && (commit_strobe || commit_now);

  // A frame accepted on a commit cycle lands in pending after the older set has moved to live.
  always_comb begin
    live_d     = live_q;
    pend_set_d = pend_set_q;
    pending_d  = pending_q;
    if (commit) begin
      live_d    = pend_set_q;
      pending_d = 1'b0;
    end
    if (rx_ok) begin
      pend_set_d = rx_set;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q     <= PARAM_DEFAULT;
      pend_set_q <= PARAM_DEFAULT;
      pending_q  <= 1'b0;
    end else begin
      live_q     <= live_d;
      pend_set_q <= pend_set_d;
      pending_q  <= pending_d;
    end
  end

  assign per       = live_q.per;
  assign p1wid     = live_q.p1wid;
  assign del       = live_q.del;
  assign p2wid     = live_q.p2wid;
  assign nut_w     = live_q.nut_w;
  assign nut_d     = live_q.nut_d;
  assign cp        = live_q.cp;
  assign p_bl      = live_q.p_bl;
  assign p_bl_off  = live_q.p_bl_off;
  assign bl        = live_q.bl[0];
  assign pending   = pending_q;
  assign frame_ok  = rx_ok;
  assign frame_err = rx_err;

  // Only bit0 of the blocking byte drives hardware.
  logic unused_bl_bits;
  assign unused_bl_bits = &{1'b0, live_q.bl[7:1]};

endmodule
